// File: rtl/sobel_pixel_streamer.sv
// Reads a frame from a synchronous-read RAM and streams it in raster order, followed by
// PAD_LINES zero lines, with a downstream stall that holds at most one returning pixel.
module sobel_pixel_streamer #(
    parameter int IMG_W     = 6,
    parameter int IMG_H     = 5,
    parameter int PAD_LINES = 1,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stall_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic [7:0]        mem_data_i,
    output logic [7:0]        grayscale_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int N     = IMG_W * IMG_H;
    localparam int PN    = PAD_LINES * IMG_W;
    localparam int CNT_W = $clog2(N + PN + 1);

    typedef enum logic [1:0] {IDLE, STREAM, PAD, DONE} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]   out_cnt;
    logic [CNT_W-1:0]   pad_cnt;
    logic               rd_pend;
    logic               hold_vld;
    logic [7:0]         hold_data;

    logic rd_issue, emit_hold, emit_mem, emit_img, emit_pad;

    // A pending hold blocks new reads so the held pixel always leaves before younger data.
    assign rd_issue  = (state == STREAM) && (rd_cnt < ADDR_W'(N)) && !stall_i && !hold_vld;
    assign emit_hold = hold_vld && !stall_i;
    assign emit_mem  = rd_pend && !stall_i;
    assign emit_img  = emit_hold || emit_mem;
    assign emit_pad  = (state == PAD) && (pad_cnt < CNT_W'(PN)) && !stall_i;

    assign mem_rd_o     = rd_issue;
    assign mem_addr_o   = rd_cnt;
    assign busy_o       = (state == STREAM) || (state == PAD);
    assign frame_done_o = (state == DONE);

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (start_i) state_next = STREAM;
            STREAM: begin
                // Entering PAD together with the last image pixel keeps pad output gapless.
                if (PAD_LINES > 0) begin
                    if (emit_img && out_cnt == CNT_W'(N - 1)) state_next = PAD;
                end else if (out_cnt == CNT_W'(N)) begin
                    state_next = DONE;
                end
            end
            PAD:    if (pad_cnt == CNT_W'(PN)) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            pad_cnt     <= '0;
            rd_pend     <= 1'b0;
            hold_vld    <= 1'b0;
            done_o      <= 1'b0;
            grayscale_o <= '0;
        end else begin
            state   <= state_next;
            rd_pend <= rd_issue;
            done_o  <= emit_img || emit_pad;

            if (state == IDLE && start_i) begin
                rd_cnt  <= '0;
                out_cnt <= '0;
                pad_cnt <= '0;
            end else begin
                if (rd_issue) rd_cnt  <= rd_cnt + ADDR_W'(1);
                if (emit_img) out_cnt <= out_cnt + CNT_W'(1);
                if (emit_pad) pad_cnt <= pad_cnt + CNT_W'(1);
            end

            if (rd_pend && stall_i) hold_vld <= 1'b1;
            else if (emit_hold)     hold_vld <= 1'b0;

            if (emit_hold)     grayscale_o <= hold_data;
            else if (emit_mem) grayscale_o <= mem_data_i;
            else if (emit_pad) grayscale_o <= '0;
        end
    end

    // NOTE: hold_data is pure datapath qualified by hold_vld, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rd_pend && stall_i) hold_data <= mem_data_i;
    end

endmodule

// File: tb/tb_sobel_pixel_streamer.sv
// Scoreboard bench for sobel_pixel_streamer: directed frames with stalls, restarts and reset,
// plus a second instance built with PAD_LINES=0.
module tb_sobel_pixel_streamer;

    typedef struct {
        logic [7:0] px;
        bit         last;
    } exp_t;

    logic        clk, rst, start_i, stall_i, start0;
    logic [15:0] mem_addr, mem_addr0;
    logic        mem_rd, mem_rd0;
    logic [7:0]  mem_data, mem_data0;
    logic [7:0]  gray, gray0;
    logic        done, done0, busy, busy0, fd, fd0;

    logic [7:0]  ram [0:31];
    exp_t        q [$];
    exp_t        q0 [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          fd_exp   = 0;
    bit          fd_exp0  = 0;
    bit          stall_prev = 0;

    sobel_pixel_streamer #(.IMG_W(6), .IMG_H(5), .PAD_LINES(1), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stall_i(stall_i),
        .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_data_i(mem_data),
        .grayscale_o(gray), .done_o(done), .busy_o(busy), .frame_done_o(fd)
    );

    sobel_pixel_streamer #(.IMG_W(6), .IMG_H(5), .PAD_LINES(0), .ADDR_W(16)) dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .stall_i(stall_i),
        .mem_addr_o(mem_addr0), .mem_rd_o(mem_rd0), .mem_data_i(mem_data0),
        .grayscale_o(gray0), .done_o(done0), .busy_o(busy0), .frame_done_o(fd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read frame RAMs holding 1..30.
    always @(posedge clk) begin
        if (mem_rd)  mem_data  <= ram[mem_addr[4:0]];
        if (mem_rd0) mem_data0 <= ram[mem_addr0[4:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int i = 1; i <= 30; i++) q.push_back('{px: 8'(i), last: 1'b0});
        for (int i = 0; i < 6; i++)   q.push_back('{px: 8'h00, last: (i == 5)});
    endtask

    task automatic push_frame0();
        for (int i = 1; i <= 30; i++) q0.push_back('{px: 8'(i), last: (i == 30)});
    endtask

    // Monitor for the padded instance: pixel order, frame_done timing, stall obedience.
    always @(negedge clk) begin
        if (rst) begin
            exp_t e;
            if (stall_prev) check("no_emit_after_stall", 32'(done), 32'd0);
            if (stall_i)    check("no_read_during_stall", 32'(mem_rd), 32'd0);
            check("frame_done", 32'(fd), 32'(fd_exp));
            if (fd) check("busy_low_at_frame_done", 32'(busy), 32'd0);
            fd_exp = 1'b0;
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_pixel", 32'(gray), 32'hffff_ffff);
                end else begin
                    e = q.pop_front();
                    check("pixel", 32'(gray), 32'(e.px));
                    fd_exp = e.last;
                end
            end
        end
        stall_prev = stall_i;
    end

    // Monitor for the unpadded instance.
    always @(negedge clk) begin
        if (rst) begin
            exp_t e;
            check("frame_done0", 32'(fd0), 32'(fd_exp0));
            fd_exp0 = 1'b0;
            if (done0) begin
                if (q0.size() == 0) begin
                    check("unexpected_pixel0", 32'(gray0), 32'hffff_ffff);
                end else begin
                    e = q0.pop_front();
                    check("pixel0", 32'(gray0), 32'(e.px));
                    fd_exp0 = e.last;
                end
            end
        end
    end

    // Cycle c starts 1 time unit after a rising edge; inputs set there apply through cycle c.
    task automatic run_test(input int id, input int ncyc);
        if (id == 8)      push_frame0();
        else if (id == 5) begin push_frame(); push_frame(); end
        else              push_frame();

        for (int c = 0; c < ncyc; c++) begin
            start_i = ((id == 1) && (c == 0 || c == 10)) ||
                      ((id >= 2 && id <= 4 || id == 6 || id == 7) && c == 0) ||
                      ((id == 5) && c <= 41);
            stall_i = ((id == 2) && c == 9) ||
                      ((id == 3) && c >= 16 && c <= 25) ||
                      ((id == 4) && c >= 33 && c <= 35);
            start0  = (id == 8) && (c == 0);
            #2;
            case (id)
                1, 7: begin
                    if (c >= 1 && c <= 30)
                        check("read_addr", 32'({mem_rd, mem_addr}), 32'({1'b1, 16'(c - 1)}));
                    if (c == 1)  check("busy_after_start", 32'(busy), 32'd1);
                    if (c == 2)  check("no_pixel_c2", 32'(done), 32'd0);
                    if (c == 3)  check("first_pixel_c3", 32'({done, gray}), 32'h101);
                    if (c == 31) check("reads_stop", 32'(mem_rd), 32'd0);
                    if (c == 33) check("pad_gapless", 32'({done, gray}), 32'h100);
                    if (c == 38) check("last_pad_c38", 32'({done, busy}), 32'h3);
                    if (c == 39) check("frame_done_c39", 32'({fd, busy}), 32'h2);
                    if (c == 40) check("frame_done_single", 32'(fd), 32'd0);
                end
                2: begin
                    if (c == 10) check("stall_bubble", 32'(done), 32'd0);
                    if (c == 11) check("held_pixel8", 32'({done, gray}), 32'h108);
                    if (c == 12) check("drain_bubble", 32'(done), 32'd0);
                    if (c == 13) check("pixel9_after_drain", 32'({done, gray}), 32'h109);
                    if (c == 41) check("frame_done_stall8", 32'(fd), 32'd1);
                end
                3: begin
                    if (c == 27) check("resume_pixel15", 32'({done, gray}), 32'h10f);
                    if (c == 28) check("resume_bubble", 32'(done), 32'd0);
                    if (c == 29) check("resume_pixel16", 32'({done, gray}), 32'h110);
                    if (c == 50) check("frame_done_long_stall", 32'(fd), 32'd1);
                end
                4: begin
                    if (c == 33) check("first_pad", 32'({done, gray}), 32'h100);
                    if (c == 36) check("pad_paused", 32'(done), 32'd0);
                    if (c == 37) check("pad_resumed", 32'({done, gray}), 32'h100);
                    if (c == 41) check("fd_waits_for_pad", 32'(fd), 32'd0);
                    if (c == 42) check("fd_after_pad", 32'(fd), 32'd1);
                end
                5: begin
                    if (c == 39) check("b2b_frame_done", 32'(fd), 32'd1);
                    if (c == 40) check("b2b_idle_gap", 32'({busy, mem_rd}), 32'd0);
                    if (c == 41) check("b2b_restart_addr0", 32'({mem_rd, mem_addr}), 32'h1_0000);
                    if (c == 79) check("b2b_second_done", 32'(fd), 32'd1);
                end
                6: begin
                    if (c == 20) begin
                        check("pre_reset_pixel18", 32'({done, gray}), 32'h112);
                        rst = 1'b0;
                        #1;
                        check("async_reset_outputs",
                              32'({done, gray, busy, fd, mem_rd}), 32'd0);
                        check("async_reset_addr", 32'(mem_addr), 32'd0);
                        q.delete();
                    end
                    if (c == 22) rst = 1'b1;
                end
                8: begin
                    if (c == 32) check("nopad_last_pixel", 32'({done0, gray0}), 32'h11e);
                    if (c == 33) check("nopad_frame_done", 32'({fd0, busy0}), 32'h2);
                end
                default: ;
            endcase
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        start0  = 1'b0;
        check("all_pixels_seen", 32'(q.size()), 32'd0);
        check("all_pixels_seen0", 32'(q0.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 8'(i + 1);
        rst      = 1'b0;
        start_i  = 1'b0;
        stall_i  = 1'b0;
        start0   = 1'b0;
        mem_data  = '0;
        mem_data0 = '0;
        repeat (2) @(posedge clk);
        #3;
        check("reset_outputs", 32'({done, gray, busy, fd, mem_rd}), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_test(1, 44);
        run_test(2, 44);
        run_test(3, 53);
        run_test(4, 45);
        run_test(5, 82);
        run_test(6, 25);
        run_test(7, 44);
        run_test(8, 36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_pixel_streamer.md
Name: sobel_pixel_streamer

Overview:
Frame-memory reader that produces the raster-order grayscale pixel stream consumed by sobel_data_buffer (grayscale_o -> grayscale_i, done_o -> done_i). On a start pulse it reads IMG_W*IMG_H pixels from a synchronous-read frame RAM. It then appends PAD_LINES lines of zero pixels so the line buffer flushes its last window row. A downstream stall input pauses the stream without losing or duplicating pixels.

Parameters:
IMG_W, 6, pixels per line
IMG_H, 5, lines per frame
PAD_LINES, 0..n, default 1, zero-valued lines appended after the image
ADDR_W, 16, frame RAM address width; must be >= clog2(IMG_W*IMG_H)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
start_i  in  1  begin a frame; sampled only in IDLE
stall_i  in  1  downstream not ready; no pixel may be emitted in the cycle after stall_i is high
mem_addr_o  out  ADDR_W  frame RAM read address, row-major, 0..IMG_W*IMG_H-1
mem_rd_o  out  1  read strobe; mem_data_i is valid exactly one cycle later
mem_data_i  in  8  frame RAM read data
grayscale_o  out  8  pixel value, registered
done_o  out  1  grayscale_o valid this cycle, registered
busy_o  out  1  high from the cycle after an accepted start until frame_done_o
frame_done_o  out  1  single-cycle pulse after the last pixel (image or pad)

Behaviour:
- One clock; reset is asynchronous and active-low. rst low forces all of the following to 0 immediately: every output, rd_cnt, out_cnt, pad_cnt and hold_vld. State goes to IDLE.
- States:
  - IDLE: start_i=1 -> STREAM; rd_cnt=out_cnt=0. stall_i is ignored.
  - STREAM -> PAD when out_cnt reaches N=IMG_W*IMG_H and PAD_LINES>0.
  - STREAM -> DONE when out_cnt reaches N and PAD_LINES=0.
  - PAD -> DONE after PAD_LINES*IMG_W pad pixels.
  - DONE: one cycle, frame_done_o=1, -> IDLE.
- Read issue (combinational): mem_rd_o = STREAM && rd_cnt<N && !stall_i && !hold_vld. mem_addr_o = rd_cnt. rd_cnt increments on each issued read.
- Data return, in the cycle after a read:
  - stall_i=0: mem_data_i loads grayscale_o and done_o=1 next cycle.
  - stall_i=1: mem_data_i is captured into hold_data and hold_vld is set. At most one held pixel.
- Hold drain: hold_vld && !stall_i -> hold_data loads grayscale_o, done_o=1 next cycle, hold_vld clears. No read is issued while hold_vld=1, which preserves ordering.
- Pad pixels: in PAD, each cycle with stall_i=0 emits 0x00 with done_o=1 next cycle.
  - Pad emission is gapless: the first pad done_o immediately follows the last image done_o when stall_i stays low.
- out_cnt/pad_cnt count done_o assertions. Exactly N + PAD_LINES*IMG_W done_o cycles per frame.
- done_o=0 in every cycle without a new pixel. grayscale_o holds its last value when done_o=0.
- Latency: start_i at cycle 0 -> busy_o=1 at cycle 1, first mem_rd_o at cycle 1, first done_o at cycle 3 (no stall).
- Sustained throughput is one pixel per cycle with no stall. Each hold drain costs one bubble cycle.
- frame_done_o is asserted the cycle after the final done_o. busy_o falls in that same cycle.
- start_i while not in IDLE is ignored. start_i held high gives back-to-back frames with the single DONE cycle between them.
- Reset mid-frame abandons the frame with no frame_done_o. After release, a new start begins again at address 0.

Test Plan:
- RAM = 1..30 (6x5), PAD_LINES=1, no stall, start at cycle 0 -> done_o high cycles 3..38. Values 1..30, then six 0x00. frame_done_o at cycle 39 only. mem_addr_o 0..29 on cycles 1..30.
- stall_i=1 for one cycle exactly when pixel 8 returns -> pixel 8 held then emitted once after stall drops. Output is 1..30 with no duplicate or gap in values. Exactly 36 done_o total.
- stall_i high 10 cycles from pixel 15 -> mem_rd_o=0 throughout the stall, done_o=0 during the stall. The sequence resumes at the correct next value.
- stall_i high during the pad line -> pad emission pauses. frame_done_o is still delayed until all 6 zeros are emitted.
- start_i pulsed at cycle 10 mid-frame -> ignored, frame unchanged. start_i held high -> second frame's first mem_rd_o at address 0 the cycle after frame_done_o+1.
- rst driven low at cycle 20 -> all outputs 0 asynchronously, no frame_done_o. Release and start -> fresh frame 1..30 from address 0. With PAD_LINES=0, frame_done_o follows pixel 30 directly.
